// File: rtl/buf_tag_scheduler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// buf_tag_scheduler_pkg: per-tag state and port-FSM encodings
// Rev 1.0
// ------------------------------------------------------------------
package buf_tag_scheduler_pkg;

  typedef logic [1:0] tag_st_t;

  localparam tag_st_t TAG_EMPTY     = 2'b00;
  localparam tag_st_t TAG_LOADING   = 2'b01;
  localparam tag_st_t TAG_READY     = 2'b10;
  localparam tag_st_t TAG_COMPUTING = 2'b11;

  // Shared by loader (L_IDLE/L_OWN) and consumer (C_IDLE/C_OWN)
  localparam logic [0:0] P_IDLE = 1'b0;
  localparam logic [0:0] P_OWN  = 1'b1;

endpackage : buf_tag_scheduler_pkg
`default_nettype wire

// File: rtl/buf_tag_scheduler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// buf_tag_scheduler_if: loader/consumer handshake and tagged addresses
// Rev 1.0
// ------------------------------------------------------------------
interface buf_tag_scheduler_if #(
  parameter int NUM_TAGS  = 2,
  parameter int WR_ADDR_W = 13,
  parameter int RD_ADDR_W = 12
);
  localparam int TAG_W = $clog2(NUM_TAGS);

  logic                      ld_req;
  logic                      ld_mode;
  logic                      ld_grant;
  logic [TAG_W-1:0]          ld_tag;
  logic                      ld_done;
  logic [WR_ADDR_W-1:0]      ld_addr;
  logic [TAG_W+WR_ADDR_W-1:0] tag_wr_addr;
  logic                      cp_req;
  logic                      cp_grant;
  logic [TAG_W-1:0]          cp_tag;
  logic                      cp_mode;
  logic                      cp_done;
  logic [RD_ADDR_W-1:0]      cp_addr;
  logic [TAG_W+RD_ADDR_W-1:0] tag_rd_addr;
  logic [2*NUM_TAGS-1:0]     tag_state;
  logic                      proto_err;

  modport master (
    output ld_req, ld_mode, ld_done, ld_addr, cp_req, cp_done, cp_addr,
    input  ld_grant, ld_tag, tag_wr_addr, cp_grant, cp_tag, cp_mode,
           tag_rd_addr, tag_state, proto_err
  );

  modport slave (
    input  ld_req, ld_mode, ld_done, ld_addr, cp_req, cp_done, cp_addr,
    output ld_grant, ld_tag, tag_wr_addr, cp_grant, cp_tag, cp_mode,
           tag_rd_addr, tag_state, proto_err
  );

endinterface : buf_tag_scheduler_if
`default_nettype wire

// File: rtl/buf_tag_port_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// buf_tag_port_fsm: IDLE/OWN owner of one tag, round-robin pointer
// Rev 1.0
// ------------------------------------------------------------------
module buf_tag_port_fsm
  import buf_tag_scheduler_pkg::*;
#(
  parameter int      NUM_TAGS = 2,
  parameter int      TAG_W    = 1,
  parameter tag_st_t FROM_ST  = TAG_EMPTY,
  parameter tag_st_t TO_ST    = TAG_LOADING,
  parameter tag_st_t DONE_ST  = TAG_READY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_i,
  input  logic                  done_i,
  input  logic [2*NUM_TAGS-1:0] tag_state_i,
  output logic                  grant_o,
  output logic [TAG_W-1:0]      tag_o,
  output logic [TAG_W-1:0]      ptr_o,
  output logic                  take_o,
  output logic                  set_o,
  output logic [TAG_W-1:0]      set_tag_o,
  output tag_st_t               set_val_o,
  output logic                  err_o
);

  logic [0:0]       fsm_q, fsm_d;
  logic [TAG_W-1:0] ptr_q, ptr_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             grant_q, grant_d;
  tag_st_t          w_ptr_st;

  assign w_ptr_st = tag_state_i[{ptr_q, 1'b0} +: 2];

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q   <= P_IDLE;
      ptr_q   <= '0;
      tag_q   <= '0;
      grant_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    grant_d = 1'b0;
    case (fsm_q)
      P_IDLE: begin
        if (take_o) begin
          fsm_d   = P_OWN;
          tag_d   = ptr_q;
          grant_d = 1'b1;
        end
      end
      P_OWN: begin
        if (done_i) begin
          fsm_d = P_IDLE;
          ptr_d = ptr_q + TAG_W'(1);
        end
      end
      default: fsm_d = P_IDLE;
    endcase
  end

  // Take and release are exclusive, so one state-write port suffices
  always_comb begin
    take_o    = (fsm_q == P_IDLE) && req_i && (w_ptr_st == FROM_ST);
    err_o     = (fsm_q == P_IDLE) && done_i;
    set_o     = 1'b0;
    set_tag_o = ptr_q;
    set_val_o = TO_ST;
    if (take_o) begin
      set_o = 1'b1;
    end else if ((fsm_q == P_OWN) && done_i) begin
      set_o     = 1'b1;
      set_tag_o = tag_q;
      set_val_o = DONE_ST;
    end
  end

  assign grant_o = grant_q;
  assign tag_o   = tag_q;
  assign ptr_o   = ptr_q;

endmodule : buf_tag_port_fsm
`default_nettype wire

// File: rtl/buf_tag_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// buf_tag_scheduler: ping-pong tag sequencing between loader and consumer
// Rev 1.0
// ------------------------------------------------------------------
module buf_tag_scheduler
  import buf_tag_scheduler_pkg::*;
#(
  parameter int NUM_TAGS = 2
) (
  input  logic               clk,
  input  logic               reset,
  buf_tag_scheduler_if.slave bus
);

  localparam int TAG_W = $clog2(NUM_TAGS);

  logic [2*NUM_TAGS-1:0] tag_state_q;
  logic [NUM_TAGS-1:0]   mode_q;
  logic                  cp_mode_q;
  logic                  proto_err_q;

  logic             w_l_grant, w_l_take, w_l_set, w_l_err;
  logic [TAG_W-1:0] w_l_tag, w_l_ptr, w_l_set_tag;
  tag_st_t          w_l_set_val;
  logic             w_c_grant, w_c_take, w_c_set, w_c_err;
  logic [TAG_W-1:0] w_c_tag, w_c_ptr, w_c_set_tag;
  tag_st_t          w_c_set_val;

  buf_tag_port_fsm #(
    .NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W),
    .FROM_ST(TAG_EMPTY), .TO_ST(TAG_LOADING), .DONE_ST(TAG_READY)
  ) u_loader (
    .clk(clk), .reset(reset), .req_i(bus.ld_req), .done_i(bus.ld_done),
    .tag_state_i(tag_state_q), .grant_o(w_l_grant), .tag_o(w_l_tag),
    .ptr_o(w_l_ptr), .take_o(w_l_take), .set_o(w_l_set),
    .set_tag_o(w_l_set_tag), .set_val_o(w_l_set_val), .err_o(w_l_err)
  );

  buf_tag_port_fsm #(
    .NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W),
    .FROM_ST(TAG_READY), .TO_ST(TAG_COMPUTING), .DONE_ST(TAG_EMPTY)
  ) u_consumer (
    .clk(clk), .reset(reset), .req_i(bus.cp_req), .done_i(bus.cp_done),
    .tag_state_i(tag_state_q), .grant_o(w_c_grant), .tag_o(w_c_tag),
    .ptr_o(w_c_ptr), .take_o(w_c_take), .set_o(w_c_set),
    .set_tag_o(w_c_set_tag), .set_val_o(w_c_set_val), .err_o(w_c_err)
  );

  // Loader and consumer only ever touch tags in disjoint states, so both writes can land
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_state_q <= '0;
      mode_q      <= '0;
      cp_mode_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        if (w_l_set && (w_l_set_tag == TAG_W'(i))) tag_state_q[2*i +: 2] <= w_l_set_val;
        if (w_c_set && (w_c_set_tag == TAG_W'(i))) tag_state_q[2*i +: 2] <= w_c_set_val;
      end
      if (w_l_take) mode_q[w_l_ptr] <= bus.ld_mode;
      if (w_c_take) cp_mode_q <= mode_q[w_c_ptr];
      proto_err_q <= proto_err_q | w_l_err | w_c_err;
    end
  end

  assign bus.ld_grant    = w_l_grant;
  assign bus.ld_tag      = w_l_tag;
  assign bus.tag_wr_addr = {w_l_tag, bus.ld_addr};
  assign bus.cp_grant    = w_c_grant;
  assign bus.cp_tag      = w_c_tag;
  assign bus.cp_mode     = cp_mode_q;
  assign bus.tag_rd_addr = {w_c_tag, bus.cp_addr};
  assign bus.tag_state   = tag_state_q;
  assign bus.proto_err   = proto_err_q;

endmodule : buf_tag_scheduler
`default_nettype wire
